// File: rtl/cpu_defs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs : shared CPU definitions
//   Opcode constants, alu_op encodings, default datapath widths and the
//   control-bundle field order.  The control unit, the ID/EX stage and the
//   EX/MEM stage all take the bundle layout from here so the order of the
//   single-bit control flags can only be changed in one place.
// -----------------------------------------------------------------------------
package cpu_defs;

  // Default datapath widths
  localparam int CPU_DATA_W = 32;
  localparam int CPU_REG_AW = 5;
  localparam int ALU_OP_W   = 2;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // alu_op encodings produced by the control unit
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [ALU_OP_W-1:0] ALU_OP_RSVD  = 2'b11;

  // Single-bit control flags, MSB first; alu_op travels alongside as its
  // own field because its width is a parameter of the stages.
  typedef struct packed {
    logic reg_dst;
    logic branch;
    logic mem_read;
    logic mem_2_reg;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic jump;
  } ctrl_flags_t;

  localparam int CTRL_FLAGS_W = $bits(ctrl_flags_t);

  // Force every control flag low unless the slot holds a real instruction.
  function automatic ctrl_flags_t gate_flags(input ctrl_flags_t f, input logic en);
    return en ? f : ctrl_flags_t'({CTRL_FLAGS_W{1'b0}});
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_hazard.sv
// -----------------------------------------------------------------------------
// hazard_detect_unit : combinational load-use detector
//   A load sitting in EX whose destination (rt) is a source of the
//   instruction in decode cannot forward in time, so decode must wait one
//   cycle.  Writes to $zero are discarded by the register file and therefore
//   never create a dependency.
// Ports
//   id_valid    in  decode slot holds a real instruction
//   ex_valid    in  EX slot holds a real instruction
//   ex_mem_read in  EX instruction is a load
//   ex_rt       in  EX load destination register
//   id_rs/id_rt in  decode source registers
//   load_use    out hazard present this cycle
// -----------------------------------------------------------------------------
module hazard_detect_unit #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              load_use
);

  // Hazard requires a live load in EX targeting a non-zero register used by decode.
  always_comb begin
    load_use = id_valid & ex_valid & ex_mem_read & (ex_rt != {REG_AW{1'b0}}) &
               ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg : ID/EX pipeline register
//   Registers the decoded control bundle, operands and register indices, one
//   cycle of latency.  Inserts a bubble on a load-use hazard, kills the decode
//   instruction on flush and freezes on ex_hold.  Edge priority:
//   flush > ex_hold > load_use > capture.
// Configuration
//   ID_EX_PERF_CNT_EN : when defined, builds saturating bubble/flush counters;
//                       otherwise perf_bubbles/perf_flushes are tied to zero.
// Ports
//   clk, arst                 clock, asynchronous active-high reset
//   id_valid, id_*            decode-slot instruction and its control bundle
//   flush                     kill decode-slot instruction
//   ex_hold                   downstream stall, freeze this stage
//   ex_valid, ex_*            registered copies of id_* (EX slot)
//   id_stall                  combinational upstream hold request
//   perf_bubbles/perf_flushes event counters
// -----------------------------------------------------------------------------
module id_ex_pipe_reg
  import cpu_defs::*;
#(
  parameter int DATA_W   = cpu_defs::CPU_DATA_W,
  parameter int REG_AW   = cpu_defs::CPU_REG_AW,
  parameter int ALU_OP_W = cpu_defs::ALU_OP_W
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                id_valid,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_reg_dst,
  input  logic                id_branch,
  input  logic                id_mem_read,
  input  logic                id_mem_2_reg,
  input  logic                id_mem_write,
  input  logic                id_alu_src,
  input  logic                id_reg_write,
  input  logic                id_jump,
  input  logic [DATA_W-1:0]   id_pc,
  input  logic [DATA_W-1:0]   id_rs_data,
  input  logic [DATA_W-1:0]   id_rt_data,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                flush,
  input  logic                ex_hold,
  output logic                ex_valid,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_reg_dst,
  output logic                ex_branch,
  output logic                ex_mem_read,
  output logic                ex_mem_2_reg,
  output logic                ex_mem_write,
  output logic                ex_alu_src,
  output logic                ex_reg_write,
  output logic                ex_jump,
  output logic [DATA_W-1:0]   ex_pc,
  output logic [DATA_W-1:0]   ex_rs_data,
  output logic [DATA_W-1:0]   ex_rt_data,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [REG_AW-1:0]   ex_rs,
  output logic [REG_AW-1:0]   ex_rt,
  output logic [REG_AW-1:0]   ex_rd,
  output logic                id_stall,
  output logic [31:0]         perf_bubbles,
  output logic [31:0]         perf_flushes
);

  // Operand / index payload; not meaningful while the slot is empty.
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } dp_t;

  logic                valid_q, valid_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  ctrl_flags_t         flags_q, flags_d, id_flags;
  dp_t                 dp_q, dp_d, id_dp;
  logic                load_use;

  assign id_flags = {id_reg_dst, id_branch, id_mem_read, id_mem_2_reg,
                     id_mem_write, id_alu_src, id_reg_write, id_jump};
  assign id_dp    = {id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd};

  hazard_detect_unit #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .id_valid    (id_valid),
    .ex_valid    (valid_q),
    .ex_mem_read (flags_q.mem_read),
    .ex_rt       (dp_q.rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .load_use    (load_use)
  );

  assign id_stall = load_use | ex_hold;

  // Next-state selection in edge-priority order; bubbles keep the stale
  // payload since only valid and the control bits must read as empty.
  always_comb begin
    valid_d  = valid_q;
    alu_op_d = alu_op_q;
    flags_d  = flags_q;
    dp_d     = dp_q;
    if (flush) begin
      valid_d  = 1'b0;
      alu_op_d = {ALU_OP_W{1'b0}};
      flags_d  = gate_flags(flags_q, 1'b0);
    end else if (ex_hold) begin
      valid_d  = valid_q;
    end else if (load_use) begin
      valid_d  = 1'b0;
      alu_op_d = {ALU_OP_W{1'b0}};
      flags_d  = gate_flags(flags_q, 1'b0);
    end else begin
      valid_d  = id_valid;
      alu_op_d = id_valid ? id_alu_op : {ALU_OP_W{1'b0}};
      flags_d  = gate_flags(id_flags, id_valid);
      dp_d     = id_dp;
    end
  end

  // Stage registers; reset empties the slot immediately.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q  <= 1'b0;
      alu_op_q <= {ALU_OP_W{1'b0}};
      flags_q  <= gate_flags(flags_q, 1'b0);
      dp_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      alu_op_q <= alu_op_d;
      flags_q  <= flags_d;
      dp_q     <= dp_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_alu_op    = alu_op_q;
  assign ex_reg_dst   = flags_q.reg_dst;
  assign ex_branch    = flags_q.branch;
  assign ex_mem_read  = flags_q.mem_read;
  assign ex_mem_2_reg = flags_q.mem_2_reg;
  assign ex_mem_write = flags_q.mem_write;
  assign ex_alu_src   = flags_q.alu_src;
  assign ex_reg_write = flags_q.reg_write;
  assign ex_jump      = flags_q.jump;
  assign ex_pc        = dp_q.pc;
  assign ex_rs_data   = dp_q.rs_data;
  assign ex_rt_data   = dp_q.rt_data;
  assign ex_imm       = dp_q.imm;
  assign ex_rs        = dp_q.rs;
  assign ex_rt        = dp_q.rt;
  assign ex_rd        = dp_q.rd;

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic        bubble_evt, flush_evt;
  logic [31:0] bubbles_q, bubbles_d, flushes_q, flushes_d;

  // A bubble is counted only when load_use actually decides the edge.
  assign bubble_evt = load_use & ~flush & ~ex_hold;
  assign flush_evt  = flush & id_valid;

  // Saturating increments.
  always_comb begin
    bubbles_d = bubbles_q;
    flushes_d = flushes_q;
    if (bubble_evt && (bubbles_q != CNT_MAX)) begin
      bubbles_d = bubbles_q + 32'd1;
    end else begin
      bubbles_d = bubbles_q;
    end
    if (flush_evt && (flushes_q != CNT_MAX)) begin
      flushes_d = flushes_q + 32'd1;
    end else begin
      flushes_d = flushes_q;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bubbles_q <= 32'd0;
      flushes_q <= 32'd0;
    end else begin
      bubbles_q <= bubbles_d;
      flushes_q <= flushes_d;
    end
  end

  assign perf_bubbles = bubbles_q;
  assign perf_flushes = flushes_q;
`else
  assign perf_bubbles = 32'd0;
  assign perf_flushes = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          id_valid = 1'b0;
  logic [OW-1:0] id_alu_op = '0;
  logic          id_reg_dst = 1'b0, id_branch = 1'b0, id_mem_read = 1'b0, id_mem_2_reg = 1'b0;
  logic          id_mem_write = 1'b0, id_alu_src = 1'b0, id_reg_write = 1'b0, id_jump = 1'b0;
  logic [DW-1:0] id_pc = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic          flush = 1'b0, ex_hold = 1'b0;

  logic          ex_valid;
  logic [OW-1:0] ex_alu_op;
  logic          ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg;
  logic          ex_mem_write, ex_alu_src, ex_reg_write, ex_jump;
  logic [DW-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic          id_stall;
  logic [31:0]   perf_bubbles, perf_flushes;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(DW), .REG_AW(AW), .ALU_OP_W(OW)) dut (
    .clk(clk), .arst(arst), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_reg_dst(id_reg_dst), .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_mem_2_reg(id_mem_2_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_jump(id_jump), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_reg_dst(ex_reg_dst),
    .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_2_reg(ex_mem_2_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_jump(ex_jump), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .id_stall(id_stall), .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: contents of the EX slot plus event counts.
  // m_ctrl layout: {alu_op, reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump}
  logic          m_valid = 1'b0;
  logic [9:0]    m_ctrl = '0;
  logic [DW-1:0] m_pc = '0, m_rs_data = '0, m_rt_data = '0, m_imm = '0;
  logic [AW-1:0] m_rs = '0, m_rt = '0, m_rd = '0;
  int            m_bub = 0;
  int            m_fl = 0;
  logic          m_stall_exp = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] id_ctrl();
    return {id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg,
            id_mem_write, id_alu_src, id_reg_write, id_jump};
  endfunction

  function automatic logic [9:0] ex_ctrl();
    return {ex_alu_op, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg,
            ex_mem_write, ex_alu_src, ex_reg_write, ex_jump};
  endfunction

  // A load in EX writing a non-zero register read by the decode instruction.
  function automatic logic model_load_use();
    return id_valid && m_valid && m_ctrl[5] && (m_rt != 0) && (m_rt == id_rs || m_rt == id_rt);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_rs_data = '0; m_rt_data = '0;
    m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_bub = 0; m_fl = 0;
  endtask

  task automatic model_edge();
    logic lu;
    lu = model_load_use();
    if (flush) begin
      if (id_valid) m_fl++;
      m_valid = 1'b0; m_ctrl = '0;
    end else if (ex_hold) begin
      m_valid = m_valid;
    end else if (lu) begin
      m_bub++;
      m_valid = 1'b0; m_ctrl = '0;
    end else begin
      m_valid = id_valid;
      m_ctrl = id_valid ? id_ctrl() : 10'd0;
      m_pc = id_pc; m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
    end
  endtask

  task automatic compare_all();
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_ctrl", ex_ctrl(), m_ctrl);
    if (m_valid) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_rs_data", ex_rs_data, m_rs_data);
      chk("ex_rt_data", ex_rt_data, m_rt_data);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_regs", {ex_rs, ex_rt, ex_rd}, {m_rs, m_rt, m_rd});
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_bubbles", perf_bubbles, m_bub);
    chk("perf_flushes", perf_flushes, m_fl);
`else
    chk("perf_bubbles", perf_bubbles, 0);
    chk("perf_flushes", perf_flushes, 0);
`endif
  endtask

  // One clock: inputs already set after a negedge; check stall, edge, check outputs.
  task automatic cycle();
    #1;
    m_stall_exp = model_load_use() | ex_hold;
    chk("id_stall", id_stall, m_stall_exp);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_instr(input logic v, input logic [9:0] c, input logic [DW-1:0] pc,
                           input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd);
    id_valid = v;
    {id_alu_op, id_reg_dst, id_branch, id_mem_read, id_mem_2_reg,
     id_mem_write, id_alu_src, id_reg_write, id_jump} = c;
    id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
  endtask

  task automatic rand_instr();
    logic [9:0] c;
    c = 10'($urandom);
    c[5] = ($urandom_range(0, 2) == 0);
    set_instr($urandom_range(0, 7) != 0, c, $urandom,
              AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom));
  endtask

  // Upstream emulation: a held instruction is re-presented unless flushed.
  task automatic run_random(input int n);
    logic prev_stall, prev_flush;
    prev_stall = 1'b0; prev_flush = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!prev_stall || prev_flush) rand_instr();
      flush   = ($urandom_range(0, 9) == 0);
      ex_hold = ($urandom_range(0, 7) == 0);
      cycle();
      prev_stall = m_stall_exp;
      prev_flush = flush;
    end
    flush = 1'b0; ex_hold = 1'b0;
  endtask

  // ctrl constants: {alu_op, reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump}
  localparam logic [9:0] C_LW  = 10'b00_0011_0110;
  localparam logic [9:0] C_ADD = 10'b10_1000_0010;
  localparam logic [9:0] C_SW  = 10'b00_0000_1100;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_ex_valid", ex_valid, 0);
    chk("reset_ctrl", ex_ctrl(), 0);
    arst = 1'b0;

    // Five load-use pairs then two flushes from a clean reset.
    for (int p = 0; p < 5; p++) begin
      set_instr(1'b1, C_LW, 32'h1000 + 32'(p * 16), 5'd29, 5'd5, 5'd0);
      cycle();
      set_instr(1'b1, C_ADD, 32'h1004 + 32'(p * 16), 5'd5, 5'd6, 5'd7);
      cycle();
      cycle();
    end
    for (int f = 0; f < 2; f++) begin
      set_instr(1'b1, C_ADD, 32'h2000 + 32'(f * 4), 5'd1, 5'd2, 5'd3);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("lit_perf_bubbles", perf_bubbles, 5);
    chk("lit_perf_flushes", perf_flushes, 2);
`else
    chk("lit_perf_bubbles", perf_bubbles, 0);
    chk("lit_perf_flushes", perf_flushes, 0);
`endif

    // lw $t0 then dependent add: one bubble, add reaches EX a cycle later.
    set_instr(1'b1, C_LW, 32'h100, 5'd29, 5'd8, 5'd0);
    cycle();
    chk("lit_lw_in_ex", {ex_valid, ex_mem_read}, 2'b11);
    set_instr(1'b1, C_ADD, 32'h104, 5'd8, 5'd9, 5'd10);
    #1 chk("lit_lu_stall", id_stall, 1);
    cycle();
    chk("lit_lu_bubble", {ex_valid, ex_reg_write}, 2'b00);
    #1 chk("lit_lu_stall_clear", id_stall, 0);
    cycle();
    chk("lit_add_in_ex", {ex_valid, ex_pc, ex_rs}, {1'b1, 32'h104, 5'd8});

    // Load to $zero never stalls.
    set_instr(1'b1, C_LW, 32'h200, 5'd29, 5'd0, 5'd0);
    cycle();
    set_instr(1'b1, C_ADD, 32'h204, 5'd0, 5'd0, 5'd11);
    #1 chk("lit_zero_no_stall", id_stall, 0);
    cycle();
    chk("lit_zero_add_in_ex", {ex_valid, ex_pc}, {1'b1, 32'h204});

    // Flush and hold together: flush wins, sw killed.
    set_instr(1'b1, C_SW, 32'h300, 5'd1, 5'd2, 5'd0);
    flush = 1'b1; ex_hold = 1'b1;
    cycle();
    chk("lit_flush_over_hold", {ex_valid, ex_mem_write}, 2'b00);
    flush = 1'b0; ex_hold = 1'b0;

    // Hold for three cycles with changing decode inputs.
    set_instr(1'b1, C_ADD, 32'h400, 5'd3, 5'd4, 5'd5);
    cycle();
    ex_hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      rand_instr();
      #1 chk("lit_hold_stall", id_stall, 1);
      cycle();
      chk("lit_hold_frozen", {ex_valid, ex_pc, ex_rd}, {1'b1, 32'h400, 5'd5});
    end
    ex_hold = 1'b0;

    run_random(400);

    // Asynchronous reset mid-traffic.
    run_random(20);
    #2;
    flush = 1'b0; ex_hold = 1'b0;
    arst = 1'b1;
    #1;
    model_reset();
    chk("lit_arst_ex_valid", ex_valid, 0);
    chk("lit_arst_ctrl", ex_ctrl(), 0);
    chk("lit_arst_data", {ex_pc, ex_rs_data, ex_rt}, 0);
    chk("lit_arst_stall", id_stall, 0);
    chk("lit_arst_perf", {perf_bubbles, perf_flushes}, 0);
    @(posedge clk);
    @(negedge clk);
    compare_all();
    arst = 1'b0;

    run_random(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
